// File: rtl/rtc_calendar_core.sv
// Calendar/timekeeping core: binary datetime registers advanced by an internal
// prescaled tick, with validated loading, 12/24h BCD output and hour:minute alarms.
module rtc_calendar_core #(
  parameter int unsigned F_CLK     = 50_000_000,
  parameter int unsigned F_FAST    = 10_000,
  parameter int unsigned YEAR_MIN  = 2000,
  parameter int unsigned YEAR_MAX  = 2099,
  parameter int unsigned NUM_ALARM = 2,
  localparam int unsigned AW = (NUM_ALARM > 1) ? $clog2(NUM_ALARM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fast,
  input  logic                 mode_12h,
  input  logic                 load_req,
  input  logic [5:0]           ld_sec,
  input  logic [5:0]           ld_min,
  input  logic [4:0]           ld_hour,
  input  logic [4:0]           ld_day,
  input  logic [3:0]           ld_mon,
  input  logic [13:0]          ld_year,
  output logic                 load_ack,
  output logic                 load_err,
  input  logic                 al_wr,
  input  logic [AW-1:0]        al_idx,
  input  logic                 al_en,
  input  logic [4:0]           al_hour,
  input  logic [5:0]           al_min,
  output logic [7:0]           sec_bcd,
  output logic [7:0]           min_bcd,
  output logic [7:0]           hour_bcd,
  output logic [7:0]           day_bcd,
  output logic [7:0]           mon_bcd,
  output logic [15:0]          year_bcd,
  output logic                 pm,
  output logic                 tick,
  output logic                 year_wrap,
  output logic [NUM_ALARM-1:0] alarm_hit
);

  localparam int unsigned PW       = (F_CLK > 1) ? $clog2(F_CLK) : 1;
  localparam int unsigned DIV_SLOW = F_CLK;
  localparam int unsigned DIV_FAST = F_CLK / F_FAST;

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == '0) && ((y % 14'd100) != '0)) || ((y % 14'd400) == '0);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [13:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hour_q, hour_d, day_q, day_d;
  logic [3:0]  mon_q, mon_d;
  logic [13:0] year_q, year_d;
  logic [PW-1:0] pre_q, pre_d;
  logic        fast_q, fast_vld_q;
  logic        tick_q, tick_d, wrap_q, wrap_d, ack_q, ack_d, err_q, err_d;
  logic [NUM_ALARM-1:0]      hit_q, hit_d, al_en_q, al_en_d;
  logic [NUM_ALARM-1:0][4:0] al_hour_q, al_hour_d;
  logic [NUM_ALARM-1:0][5:0] al_min_q, al_min_d;

  logic [5:0]  n_sec, n_min;
  logic [4:0]  n_hour, n_day;
  logic [3:0]  n_mon;
  logic [13:0] n_year;
  logic        n_wrap;
  logic        fast_chg, tick_int, tick_eff, ld_valid, load_ok;
  logic [PW-1:0] div_m1;
  logic [4:0]  hour_disp;

  // Carry chain for one-second advance, evaluated every cycle.
  always_comb begin
    n_sec  = sec_q;
    n_min  = min_q;
    n_hour = hour_q;
    n_day  = day_q;
    n_mon  = mon_q;
    n_year = year_q;
    n_wrap = 1'b0;
    if (sec_q >= 6'd59) begin
      n_sec = '0;
      if (min_q >= 6'd59) begin
        n_min = '0;
        if (hour_q >= 5'd23) begin
          n_hour = '0;
          if (day_q >= month_len(mon_q, year_q)) begin
            n_day = 5'd1;
            if (mon_q >= 4'd12) begin
              n_mon = 4'd1;
              if (year_q >= 14'(YEAR_MAX)) begin
                n_year = 14'(YEAR_MIN);
                n_wrap = 1'b1;
              end else begin
                n_year = year_q + 14'd1;
              end
            end else begin
              n_mon = mon_q + 4'd1;
            end
          end else begin
            n_day = day_q + 5'd1;
          end
        end else begin
          n_hour = hour_q + 5'd1;
        end
      end else begin
        n_min = min_q + 6'd1;
      end
    end else begin
      n_sec = sec_q + 6'd1;
    end
  end

  always_comb begin
    ld_valid = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (ld_hour <= 5'd23) &&
               (ld_mon >= 4'd1) && (ld_mon <= 4'd12) && (ld_day != '0) &&
               (ld_day <= month_len(ld_mon, ld_year)) &&
               (ld_year >= 14'(YEAR_MIN)) && (ld_year <= 14'(YEAR_MAX));
    load_ok  = load_req && ld_valid;
    // fast_q only becomes a valid reference one cycle after reset, so the
    // reset state of fast never counts as a change.
    fast_chg = fast_vld_q && (fast != fast_q);
    div_m1   = fast ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);
    tick_int = en && !fast_chg && (pre_q == div_m1);
    tick_eff = tick_int && !load_ok;

    pre_d = pre_q;
    if (load_ok || fast_chg) pre_d = '0;
    else if (en)             pre_d = tick_int ? '0 : pre_q + PW'(1);

    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = day_q;
    mon_d  = mon_q;
    year_d = year_q;
    if (load_ok) begin
      sec_d  = ld_sec;
      min_d  = ld_min;
      hour_d = ld_hour;
      day_d  = ld_day;
      mon_d  = ld_mon;
      year_d = ld_year;
    end else if (tick_eff) begin
      sec_d  = n_sec;
      min_d  = n_min;
      hour_d = n_hour;
      day_d  = n_day;
      mon_d  = n_mon;
      year_d = n_year;
    end

    tick_d = tick_eff;
    wrap_d = tick_eff && n_wrap;
    ack_d  = load_ok;
    err_d  = load_req && !ld_valid;

    al_en_d   = al_en_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    hit_d     = '0;
    for (int unsigned i = 0; i < NUM_ALARM; i++) begin
      hit_d[i] = tick_eff && al_en_q[i] && (n_sec == '0) &&
                 (n_hour == al_hour_q[i]) && (n_min == al_min_q[i]);
      if (al_wr && (al_idx == AW'(i))) begin
        al_en_d[i]   = al_en;
        al_hour_d[i] = al_hour;
        al_min_d[i]  = al_min;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      day_q      <= 5'd1;
      mon_q      <= 4'd1;
      year_q     <= 14'(YEAR_MIN);
      pre_q      <= '0;
      fast_q     <= 1'b0;
      fast_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= '0;
      al_en_q    <= '0;
      al_hour_q  <= '0;
      al_min_q   <= '0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      mon_q      <= mon_d;
      year_q     <= year_d;
      pre_q      <= pre_d;
      fast_q     <= fast;
      fast_vld_q <= 1'b1;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      al_en_q    <= al_en_d;
      al_hour_q  <= al_hour_d;
      al_min_q   <= al_min_d;
    end
  end

  always_comb begin
    hour_disp = hour_q;
    if (mode_12h) begin
      if (hour_q == '0)        hour_disp = 5'd12;
      else if (hour_q > 5'd12) hour_disp = hour_q - 5'd12;
    end
  end

  assign sec_bcd   = bcd2({1'b0, sec_q});
  assign min_bcd   = bcd2({1'b0, min_q});
  assign hour_bcd  = bcd2({2'b0, hour_disp});
  assign day_bcd   = bcd2({2'b0, day_q});
  assign mon_bcd   = bcd2({3'b0, mon_q});
  assign year_bcd  = {4'(year_q / 14'd1000), 4'((year_q / 14'd100) % 14'd10),
                      4'((year_q / 14'd10) % 14'd10), 4'(year_q % 14'd10)};
  assign pm        = (hour_q >= 5'd12);
  assign tick      = tick_q;
  assign year_wrap = wrap_q;
  assign load_ack  = ack_q;
  assign load_err  = err_q;
  assign alarm_hit = hit_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core: two instances (YEAR_MAX 2099 and 2199)
// share all inputs; expected datetimes are written as packed BCD constants.
module tb_rtc_calendar_core;

  logic        clk = 1'b0;
  logic        rst_n, en, fast, mode_12h, load_req;
  logic [5:0]  ld_sec, ld_min;
  logic [4:0]  ld_hour, ld_day;
  logic [3:0]  ld_mon;
  logic [13:0] ld_year;
  logic        al_wr, al_idx, al_en;
  logic [4:0]  al_hour;
  logic [5:0]  al_min;

  logic        load_ack, load_err, pm, tick, year_wrap;
  logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, mon_bcd;
  logic [15:0] year_bcd;
  logic [1:0]  alarm_hit;

  logic        load_ack_b, load_err_b, pm_b, tick_b, year_wrap_b;
  logic [7:0]  sec_bcd_b, min_bcd_b, hour_bcd_b, day_bcd_b, mon_bcd_b;
  logic [15:0] year_bcd_b;
  logic [1:0]  alarm_hit_b;

  logic [55:0] now_a, now_b;
  assign now_a = {year_bcd, mon_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd};
  assign now_b = {year_bcd_b, mon_bcd_b, day_bcd_b, hour_bcd_b, min_bcd_b, sec_bcd_b};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_calendar_core #(.F_CLK(100), .F_FAST(10), .YEAR_MIN(2000), .YEAR_MAX(2099), .NUM_ALARM(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fast(fast), .mode_12h(mode_12h),
    .load_req(load_req), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
    .ld_day(ld_day), .ld_mon(ld_mon), .ld_year(ld_year),
    .load_ack(load_ack), .load_err(load_err),
    .al_wr(al_wr), .al_idx(al_idx), .al_en(al_en), .al_hour(al_hour), .al_min(al_min),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
    .mon_bcd(mon_bcd), .year_bcd(year_bcd), .pm(pm), .tick(tick),
    .year_wrap(year_wrap), .alarm_hit(alarm_hit)
  );

  rtc_calendar_core #(.F_CLK(100), .F_FAST(10), .YEAR_MIN(2000), .YEAR_MAX(2199), .NUM_ALARM(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fast(fast), .mode_12h(mode_12h),
    .load_req(load_req), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
    .ld_day(ld_day), .ld_mon(ld_mon), .ld_year(ld_year),
    .load_ack(load_ack_b), .load_err(load_err_b),
    .al_wr(al_wr), .al_idx(al_idx), .al_en(al_en), .al_hour(al_hour), .al_min(al_min),
    .sec_bcd(sec_bcd_b), .min_bcd(min_bcd_b), .hour_bcd(hour_bcd_b), .day_bcd(day_bcd_b),
    .mon_bcd(mon_bcd_b), .year_bcd(year_bcd_b), .pm(pm_b), .tick(tick_b),
    .year_wrap(year_wrap_b), .alarm_hit(alarm_hit_b)
  );

  // Drives one load_req cycle; ack/err are sampled just after the applying edge.
  task automatic do_load(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, output logic ack, output logic err);
    @(negedge clk);
    ld_year = 14'(y); ld_mon = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h);  ld_min = 6'(mi); ld_sec = 6'(s);
    load_req = 1'b1;
    @(posedge clk); #1;
    ack = load_ack; err = load_err;
    load_req = 1'b0;
  endtask

  task automatic do_alarm(input logic idx, input logic e, input int h, input int mi);
    @(negedge clk);
    al_idx = idx; al_en = e; al_hour = 5'(h); al_min = 6'(mi); al_wr = 1'b1;
    @(posedge clk); #1;
    al_wr = 1'b0;
  endtask

  // Returns number of edges until the selected instance shows tick, or -1.
  task automatic wait_tick(input logic sel_b, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if ((sel_b ? tick_b : tick) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; en = 1'b1; fast = 1'b1; mode_12h = 1'b0; load_req = 1'b0;
    ld_sec = '0; ld_min = '0; ld_hour = '0; ld_day = '0; ld_mon = '0; ld_year = '0;
    al_wr = 1'b0; al_idx = 1'b0; al_en = 1'b0; al_hour = '0; al_min = '0;
    #23;
    checks++; if (now_a !== 56'h2000_01_01_00_00_00) begin errors++; $display("FAIL reset_time: got %h exp %h", now_a, 56'h2000_01_01_00_00_00); end
    checks++; if ({tick, year_wrap, load_ack, load_err, alarm_hit} !== 6'b0) begin errors++; $display("FAIL reset_pulses: got %b exp 000000", {tick, year_wrap, load_ack, load_err, alarm_hit}); end
    @(negedge clk); rst_n = 1'b1;
    wait_tick(1'b0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL first_tick_latency: got %0d exp 10", n); end
    checks++; if (now_a !== 56'h2000_01_01_00_00_01) begin errors++; $display("FAIL first_tick_time: got %h exp %h", now_a, 56'h2000_01_01_00_00_01); end
    @(posedge clk); #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b exp 0", tick); end
    wait_tick(1'b0, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL tick_period: got %0d exp 9 more edges", n); end
    checks++; if (now_a !== 56'h2000_01_01_00_00_02) begin errors++; $display("FAIL second_tick_time: got %h exp %h", now_a, 56'h2000_01_01_00_00_02); end
  endtask

  task automatic test_leap;
    logic a, e;
    int n;
    do_load(2024, 2, 28, 23, 59, 59, a, e);
    checks++; if ({a, e} !== 2'b10) begin errors++; $display("FAIL leap2024_ack: got %b exp 10", {a, e}); end
    wait_tick(1'b0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL tick_after_load: got %0d exp 10", n); end
    checks++; if (now_a !== 56'h2024_02_29_00_00_00) begin errors++; $display("FAIL leap2024: got %h exp %h", now_a, 56'h2024_02_29_00_00_00); end
    do_load(2023, 2, 28, 23, 59, 59, a, e);
    wait_tick(1'b0, n);
    checks++; if (now_a !== 56'h2023_03_01_00_00_00) begin errors++; $display("FAIL nonleap2023: got %h exp %h", now_a, 56'h2023_03_01_00_00_00); end
    do_load(2100, 2, 28, 23, 59, 59, a, e);
    checks++; if ({a, e} !== 2'b01) begin errors++; $display("FAIL year_above_max_err: got %b exp 01", {a, e}); end
    checks++; if ({load_ack_b, load_err_b} !== 2'b10) begin errors++; $display("FAIL b_2100_ack: got %b exp 10", {load_ack_b, load_err_b}); end
    wait_tick(1'b1, n);
    checks++; if (now_b !== 56'h2100_03_01_00_00_00) begin errors++; $display("FAIL century2100: got %h exp %h", now_b, 56'h2100_03_01_00_00_00); end
    do_load(2000, 2, 29, 23, 59, 59, a, e);
    checks++; if ({a, e} !== 2'b10) begin errors++; $display("FAIL leap2000_ack: got %b exp 10", {a, e}); end
    checks++; if (now_a !== 56'h2000_02_29_23_59_59) begin errors++; $display("FAIL leap2000_time: got %h exp %h", now_a, 56'h2000_02_29_23_59_59); end
  endtask

  task automatic test_year_wrap;
    logic a, e;
    int n;
    do_load(2099, 12, 31, 23, 59, 59, a, e);
    wait_tick(1'b0, n);
    checks++; if (now_a !== 56'h2000_01_01_00_00_00) begin errors++; $display("FAIL wrap_time: got %h exp %h", now_a, 56'h2000_01_01_00_00_00); end
    checks++; if (year_wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %b exp 1", year_wrap); end
    checks++; if ({now_b, year_wrap_b} !== {56'h2100_01_01_00_00_00, 1'b0}) begin errors++; $display("FAIL b_no_wrap: got %h/%b exp 21000101000000/0", now_b, year_wrap_b); end
    @(posedge clk); #1;
    checks++; if (year_wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %b exp 0", year_wrap); end
  endtask

  task automatic test_invalid_load;
    logic a, e;
    int n;
    do_load(2023, 5, 10, 10, 20, 30, a, e);
    do_load(2023, 4, 31, 10, 20, 30, a, e);
    checks++; if ({a, e} !== 2'b01) begin errors++; $display("FAIL apr31_err: got %b exp 01", {a, e}); end
    checks++; if (now_a !== 56'h2023_05_10_10_20_30) begin errors++; $display("FAIL apr31_unchanged: got %h exp %h", now_a, 56'h2023_05_10_10_20_30); end
    do_load(2023, 2, 29, 1, 1, 1, a, e);
    checks++; if ({a, e} !== 2'b01) begin errors++; $display("FAIL feb29_2023_err: got %b exp 01", {a, e}); end
    do_load(2023, 5, 10, 24, 0, 0, a, e);
    checks++; if ({a, e} !== 2'b01) begin errors++; $display("FAIL hour24_err: got %b exp 01", {a, e}); end
    do_load(1999, 12, 31, 0, 0, 0, a, e);
    checks++; if ({a, e} !== 2'b01) begin errors++; $display("FAIL year_below_min_err: got %b exp 01", {a, e}); end
    checks++; if (now_a !== 56'h2023_05_10_10_20_30) begin errors++; $display("FAIL invalid_unchanged: got %h exp %h", now_a, 56'h2023_05_10_10_20_30); end
    // Valid load on the tick cycle: loaded value, no tick.
    do_load(2023, 5, 10, 10, 20, 30, a, e);
    repeat (9) @(posedge clk);
    do_load(2023, 8, 15, 12, 0, 0, a, e);
    checks++; if ({a, e, tick} !== 3'b100) begin errors++; $display("FAIL load_vs_tick: got ack/err/tick %b exp 100", {a, e, tick}); end
    checks++; if (now_a !== 56'h2023_08_15_12_00_00) begin errors++; $display("FAIL load_vs_tick_time: got %h exp %h", now_a, 56'h2023_08_15_12_00_00); end
    // Invalid load on the tick cycle: tick proceeds.
    repeat (9) @(posedge clk);
    do_load(2023, 13, 1, 0, 0, 0, a, e);
    checks++; if ({a, e, tick} !== 3'b011) begin errors++; $display("FAIL err_vs_tick: got ack/err/tick %b exp 011", {a, e, tick}); end
    checks++; if (now_a !== 56'h2023_08_15_12_00_01) begin errors++; $display("FAIL err_vs_tick_time: got %h exp %h", now_a, 56'h2023_08_15_12_00_01); end
  endtask

  task automatic test_back_to_back;
    logic a1, e1, a2, e2;
    do_load(2023, 6, 1, 1, 2, 3, a1, e1);
    do_load(2023, 6, 2, 4, 5, 6, a2, e2);
    checks++; if ({a1, e1, a2, e2} !== 4'b1010) begin errors++; $display("FAIL b2b_acks: got %b exp 1010", {a1, e1, a2, e2}); end
    checks++; if (now_a !== 56'h2023_06_02_04_05_06) begin errors++; $display("FAIL b2b_time: got %h exp %h", now_a, 56'h2023_06_02_04_05_06); end
  endtask

  task automatic test_12h;
    logic a, e;
    mode_12h = 1'b1;
    do_load(2023, 1, 1, 0, 10, 0, a, e);
    checks++; if ({hour_bcd, pm} !== {8'h12, 1'b0}) begin errors++; $display("FAIL h12_midnight: got %h/%b exp 12/0", hour_bcd, pm); end
    do_load(2023, 1, 1, 13, 10, 0, a, e);
    checks++; if ({hour_bcd, pm} !== {8'h01, 1'b1}) begin errors++; $display("FAIL h12_13: got %h/%b exp 01/1", hour_bcd, pm); end
    do_load(2023, 1, 1, 12, 10, 0, a, e);
    checks++; if ({hour_bcd, pm} !== {8'h12, 1'b1}) begin errors++; $display("FAIL h12_noon: got %h/%b exp 12/1", hour_bcd, pm); end
    do_load(2023, 1, 1, 11, 10, 0, a, e);
    checks++; if ({hour_bcd, pm} !== {8'h11, 1'b0}) begin errors++; $display("FAIL h12_11: got %h/%b exp 11/0", hour_bcd, pm); end
    mode_12h = 1'b0;
    do_load(2023, 1, 1, 23, 10, 0, a, e);
    checks++; if ({hour_bcd, pm} !== {8'h23, 1'b1}) begin errors++; $display("FAIL h24_23: got %h/%b exp 23/1", hour_bcd, pm); end
  endtask

  task automatic test_alarm;
    logic a, e;
    int n;
    do_alarm(1'b1, 1'b1, 7, 30);
    do_load(2023, 3, 3, 7, 29, 59, a, e);
    wait_tick(1'b0, n);
    checks++; if (alarm_hit !== 2'b10) begin errors++; $display("FAIL alarm1_hit: got %b exp 10", alarm_hit); end
    checks++; if (now_a !== 56'h2023_03_03_07_30_00) begin errors++; $display("FAIL alarm1_time: got %h exp %h", now_a, 56'h2023_03_03_07_30_00); end
    @(posedge clk); #1;
    checks++; if (alarm_hit !== 2'b00) begin errors++; $display("FAIL alarm_one_cycle: got %b exp 00", alarm_hit); end
    do_load(2023, 3, 3, 7, 30, 0, a, e);
    checks++; if (alarm_hit !== 2'b00) begin errors++; $display("FAIL alarm_on_load: got %b exp 00", alarm_hit); end
    wait_tick(1'b0, n);
    checks++; if (alarm_hit !== 2'b00) begin errors++; $display("FAIL alarm_after_load_tick: got %b exp 00", alarm_hit); end
    do_alarm(1'b0, 1'b1, 8, 0);
    do_load(2023, 3, 3, 7, 59, 59, a, e);
    wait_tick(1'b0, n);
    checks++; if (alarm_hit !== 2'b01) begin errors++; $display("FAIL alarm0_hit: got %b exp 01", alarm_hit); end
    do_alarm(1'b1, 1'b0, 7, 30);
    do_load(2023, 3, 3, 7, 29, 59, a, e);
    wait_tick(1'b0, n);
    checks++; if (alarm_hit !== 2'b00) begin errors++; $display("FAIL alarm1_disabled: got %b exp 00", alarm_hit); end
    checks++; if (n !== 10) begin errors++; $display("FAIL alarm_tick_timeout: got %0d exp 10", n); end
  endtask

  initial begin
    test_reset;
    test_leap;
    test_year_wrap;
    test_invalid_load;
    test_back_to_back;
    test_12h;
    test_alarm;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
